// File: rtl/ldst_bus_arb.sv
// Two-requester round-robin arbiter for the load/store bus.
// m0 = EXU ldst handler, m1 = debug/DMA port. Granted requester IDs are kept
// in an in-order FIFO so each slave response is routed back to its owner with
// no added latency in either direction.
module ldst_bus_arb #(
    parameter int XLEN     = 32,
    parameter int OT_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m0_req_vld,
    output logic                          m0_req_rdy,
    input  logic [XLEN-1:0]               m0_req_addr,
    input  logic                          m0_req_st,
    input  logic [XLEN-1:0]               m0_req_data,
    input  logic [3:0]                    m0_req_strobe,
    output logic                          m0_rsp_vld,
    input  logic                          m0_rsp_rdy,
    output logic [XLEN-1:0]               m0_rsp_data,
    input  logic                          m1_req_vld,
    output logic                          m1_req_rdy,
    input  logic [XLEN-1:0]               m1_req_addr,
    input  logic                          m1_req_st,
    input  logic [XLEN-1:0]               m1_req_data,
    input  logic [3:0]                    m1_req_strobe,
    output logic                          m1_rsp_vld,
    input  logic                          m1_rsp_rdy,
    output logic [XLEN-1:0]               m1_rsp_data,
    output logic                          s_req_vld,
    input  logic                          s_req_rdy,
    output logic [XLEN-1:0]               s_req_addr,
    output logic                          s_req_st,
    output logic [XLEN-1:0]               s_req_data,
    output logic [3:0]                    s_req_strobe,
    input  logic                          s_rsp_vld,
    output logic                          s_rsp_rdy,
    input  logic [XLEN-1:0]               s_rsp_data,
    output logic [$clog2(OT_DEPTH):0]     ot_cnt,
    output logic                          err_unexp_rsp
);

    localparam int PW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CW = $clog2(OT_DEPTH) + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(OT_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OT_DEPTH);

    // ST_ARB: free arbitration; ST_HOLD: slave stalled, grant pinned to lock_id
    typedef enum logic {ST_ARB, ST_HOLD} state_t;

    state_t              state_q, state_d;
    logic                lock_id_q, lock_id_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                err_q, err_d;
    logic [CW-1:0]       ot_cnt_q, ot_cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OT_DEPTH-1:0] id_fifo_q, id_fifo_d;

    logic gnt_vld, gnt_id, full, empty, head_id, req_hs, rsp_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Grant selection: a pinned grant wins, then a lone requester, then rr_ptr on a tie
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state_q == ST_HOLD) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id_q;
        end else if (m0_req_vld && m1_req_vld) begin
            gnt_vld = 1'b1;
            gnt_id  = rr_ptr_q;
        end else if (m0_req_vld) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end else if (m1_req_vld) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never unblocks a push
    assign full  = (ot_cnt_q == CNT_FULL);
    assign empty = (ot_cnt_q == '0);

    assign s_req_vld    = gnt_vld & ~full;
    assign s_req_addr   = gnt_id ? m1_req_addr   : m0_req_addr;
    assign s_req_st     = gnt_id ? m1_req_st     : m0_req_st;
    assign s_req_data   = gnt_id ? m1_req_data   : m0_req_data;
    assign s_req_strobe = gnt_id ? m1_req_strobe : m0_req_strobe;
    assign m0_req_rdy   = s_req_vld & ~gnt_id & s_req_rdy;
    assign m1_req_rdy   = s_req_vld &  gnt_id & s_req_rdy;
    assign req_hs       = s_req_vld & s_req_rdy;

    // With nothing outstanding a response is swallowed (and flagged) rather than routed
    assign head_id     = id_fifo_q[rd_ptr_q];
    assign m0_rsp_vld  = s_rsp_vld & ~empty & ~head_id;
    assign m1_rsp_vld  = s_rsp_vld & ~empty &  head_id;
    assign s_rsp_rdy   = empty ? s_rsp_vld : (head_id ? m1_rsp_rdy : m0_rsp_rdy);
    assign rsp_pop     = s_rsp_vld & s_rsp_rdy & ~empty;
    assign m0_rsp_data = s_rsp_data;
    assign m1_rsp_data = s_rsp_data;

    assign ot_cnt        = ot_cnt_q;
    assign err_unexp_rsp = err_q;

    // Next-state: lock FSM, round-robin pointer, ID FIFO and outstanding count
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        id_fifo_d = id_fifo_q;
        ot_cnt_d  = ot_cnt_q;
        err_d     = err_q | (s_rsp_vld & empty);

        case (state_q)
            ST_ARB: begin
                if (s_req_vld && !s_req_rdy) begin
                    state_d   = ST_HOLD;
                    lock_id_d = gnt_id;
                end
            end
            ST_HOLD: begin
                if (req_hs) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase

        if (req_hs) begin
            id_fifo_d[wr_ptr_q] = gnt_id;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            rr_ptr_d            = ~gnt_id;
        end
        if (rsp_pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({req_hs, rsp_pop})
            2'b10:   ot_cnt_d = ot_cnt_q + 1'b1;
            2'b01:   ot_cnt_d = ot_cnt_q - 1'b1;
            default: ot_cnt_d = ot_cnt_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARB;
            lock_id_q <= 1'b0;
            rr_ptr_q  <= 1'b0;
            err_q     <= 1'b0;
            ot_cnt_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            id_fifo_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
            ot_cnt_q  <= ot_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            id_fifo_q <= id_fifo_d;
        end
    end

endmodule

// File: tb/tb_ldst_bus_arb.sv
// Bench for ldst_bus_arb: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the outstanding requests.
module tb_ldst_bus_arb;

    localparam int XLEN     = 32;
    localparam int OT_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m0_req_vld, m0_req_rdy, m0_req_st, m0_rsp_vld, m0_rsp_rdy;
    logic m1_req_vld, m1_req_rdy, m1_req_st, m1_rsp_vld, m1_rsp_rdy;
    logic [XLEN-1:0] m0_req_addr, m0_req_data, m0_rsp_data;
    logic [XLEN-1:0] m1_req_addr, m1_req_data, m1_rsp_data;
    logic [3:0] m0_req_strobe, m1_req_strobe, s_req_strobe;
    logic s_req_vld, s_req_rdy, s_req_st, s_rsp_vld, s_rsp_rdy;
    logic [XLEN-1:0] s_req_addr, s_req_data, s_rsp_data;
    logic [$clog2(OT_DEPTH):0] ot_cnt;
    logic err_unexp_rsp;

    ldst_bus_arb #(.XLEN(XLEN), .OT_DEPTH(OT_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
        .m0_req_st(m0_req_st), .m0_req_data(m0_req_data), .m0_req_strobe(m0_req_strobe),
        .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_data(m0_rsp_data),
        .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
        .m1_req_st(m1_req_st), .m1_req_data(m1_req_data), .m1_req_strobe(m1_req_strobe),
        .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_data(m1_rsp_data),
        .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_addr(s_req_addr),
        .s_req_st(s_req_st), .s_req_data(s_req_data), .s_req_strobe(s_req_strobe),
        .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_data(s_rsp_data),
        .ot_cnt(ot_cnt), .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: outstanding owner IDs in issue order, tie preference, stall lock
    int exp_q[$];
    int pref     = 0;
    bit locked   = 1'b0;
    int lock_who = 0;
    bit err_m    = 1'b0;
    bit acc0     = 1'b0;
    bit acc1     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pref = 0; locked = 1'b0; lock_who = 0; err_m = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    endtask

    task automatic clear_inputs();
        m0_req_vld = 0; m0_req_addr = '0; m0_req_st = 0; m0_req_data = '0; m0_req_strobe = '0;
        m1_req_vld = 0; m1_req_addr = '0; m1_req_st = 0; m1_req_data = '0; m1_req_strobe = '0;
        m0_rsp_rdy = 0; m1_rsp_rdy = 0;
        s_req_rdy = 0; s_rsp_vld = 0; s_rsp_data = '0;
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one clock: optionally randomize inputs, check every output against the model, advance model
    task automatic cycle(input bit rnd);
        int sz, g;
        bit gv, full, e_svld, e_srdy, e_rv0, e_rv1, hs, pop;
        if (rnd) begin
            if (!(m0_req_vld && !acc0)) begin
                m0_req_vld    = ($urandom_range(0, 99) < 45);
                m0_req_addr   = $urandom;
                m0_req_st     = 1'($urandom_range(0, 1));
                m0_req_data   = $urandom;
                m0_req_strobe = 4'($urandom_range(0, 15));
            end
            if (!(m1_req_vld && !acc1)) begin
                m1_req_vld    = ($urandom_range(0, 99) < 45);
                m1_req_addr   = $urandom;
                m1_req_st     = 1'($urandom_range(0, 1));
                m1_req_data   = $urandom;
                m1_req_strobe = 4'($urandom_range(0, 15));
            end
            s_req_rdy  = ($urandom_range(0, 99) < 65);
            s_rsp_vld  = (exp_q.size() > 0) ? ($urandom_range(0, 99) < 55)
                                             : ($urandom_range(0, 99) < 2);
            s_rsp_data = $urandom;
            m0_rsp_rdy = ($urandom_range(0, 99) < 70);
            m1_rsp_rdy = ($urandom_range(0, 99) < 70);
        end
        #1;
        sz   = exp_q.size();
        full = (sz == OT_DEPTH);
        gv   = 1'b1;
        g    = 0;
        if (locked)                        g = lock_who;
        else if (m0_req_vld && m1_req_vld) g = pref;
        else if (m0_req_vld)               g = 0;
        else if (m1_req_vld)               g = 1;
        else                               gv = 1'b0;
        e_svld = gv && !full;
        chk("s_req_vld",  32'(s_req_vld),  32'(e_svld));
        chk("m0_req_rdy", 32'(m0_req_rdy), 32'(e_svld && g == 0 && s_req_rdy));
        chk("m1_req_rdy", 32'(m1_req_rdy), 32'(e_svld && g == 1 && s_req_rdy));
        if (gv) begin
            chk("s_req_addr",   s_req_addr,         (g == 1) ? m1_req_addr : m0_req_addr);
            chk("s_req_st",     32'(s_req_st),      32'((g == 1) ? m1_req_st : m0_req_st));
            chk("s_req_data",   s_req_data,         (g == 1) ? m1_req_data : m0_req_data);
            chk("s_req_strobe", 32'(s_req_strobe),  32'((g == 1) ? m1_req_strobe : m0_req_strobe));
        end
        e_rv0  = s_rsp_vld && sz > 0 && exp_q[0] == 0;
        e_rv1  = s_rsp_vld && sz > 0 && exp_q[0] == 1;
        e_srdy = (sz == 0) ? s_rsp_vld : ((exp_q[0] == 0) ? m0_rsp_rdy : m1_rsp_rdy);
        chk("m0_rsp_vld",  32'(m0_rsp_vld), 32'(e_rv0));
        chk("m1_rsp_vld",  32'(m1_rsp_vld), 32'(e_rv1));
        chk("s_rsp_rdy",   32'(s_rsp_rdy),  32'(e_srdy));
        if (e_rv0) chk("m0_rsp_data", m0_rsp_data, s_rsp_data);
        if (e_rv1) chk("m1_rsp_data", m1_rsp_data, s_rsp_data);
        chk("ot_cnt",        32'(ot_cnt),        32'(sz));
        chk("err_unexp_rsp", 32'(err_unexp_rsp), 32'(err_m));
        hs  = e_svld && s_req_rdy;
        pop = s_rsp_vld && e_srdy && sz > 0;
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (hs) begin
            exp_q.push_back(g);
            pref = 1 - g;
        end
        if (s_rsp_vld && sz == 0) err_m = 1'b1;
        if (hs)          locked = 1'b0;
        else if (e_svld) begin
            locked   = 1'b1;
            lock_who = g;
        end
        acc0 = hs && g == 0;
        acc1 = hs && g == 1;
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_req_vld", 32'(s_req_vld), 32'd0);
        chk("rst_s_rsp_rdy", 32'(s_rsp_rdy), 32'd0);
        chk("rst_ot_cnt",    32'(ot_cnt),    32'd0);
        chk("rst_err",       32'(err_unexp_rsp), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: single m0 load and its response
        m0_req_vld = 1; m0_req_addr = 32'h100; s_req_rdy = 1;
        #1;
        chk("t1_addr",   s_req_addr,       32'h100);
        chk("t1_m0_rdy", 32'(m0_req_rdy),  32'd1);
        cycle(0);
        m0_req_vld = 0; s_rsp_vld = 1; s_rsp_data = 32'hDEADBEEF; m0_rsp_rdy = 1;
        #1;
        chk("t1_ot_cnt1",   32'(ot_cnt),     32'd1);
        chk("t1_m0_rspv",   32'(m0_rsp_vld), 32'd1);
        chk("t1_m0_rspd",   m0_rsp_data,     32'hDEADBEEF);
        chk("t1_m1_rspv",   32'(m1_rsp_vld), 32'd0);
        cycle(0);
        s_rsp_vld = 0;
        #1;
        chk("t1_ot_cnt0", 32'(ot_cnt), 32'd0);

        // T2: continuous contention alternates m0,m1,m0,m1
        do_reset();
        m0_req_vld = 1; m1_req_vld = 1; s_req_rdy = 1; m0_rsp_rdy = 1; m1_rsp_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            s_rsp_vld = (i > 0);
            #1;
            chk("t2_m1_grant", 32'(m1_req_rdy), 32'(i % 2));
            chk("t2_m0_grant", 32'(m0_req_rdy), 32'((i + 1) % 2));
            cycle(0);
        end

        // T3: stalled m1 store holds the bus while m0 waits
        do_reset();
        m1_req_vld = 1; m1_req_addr = 32'h200; m1_req_st = 1; m1_req_data = 32'h55; m1_req_strobe = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                m0_req_vld = 1; m0_req_addr = 32'h300;
            end
            #1;
            chk("t3_hold_addr", s_req_addr, 32'h200);
            cycle(0);
        end
        s_req_rdy = 1;
        #1;
        chk("t3_m1_hs", 32'(m1_req_rdy), 32'd1);
        chk("t3_m0_wait", 32'(m0_req_rdy), 32'd0);
        cycle(0);
        m1_req_vld = 0;
        #1;
        chk("t3_m0_next", 32'(m0_req_rdy), 32'd1);
        chk("t3_m0_addr", s_req_addr, 32'h300);
        cycle(0);

        // T4: full FIFO blocks, a same-cycle pop does not unblock
        do_reset();
        m0_req_vld = 1; s_req_rdy = 1; m0_rsp_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_m0_rdy", 32'(m0_req_rdy), (i < 2) ? 32'd1 : 32'd0);
            cycle(0);
        end
        chk("t4_ot_full", 32'(ot_cnt), 32'd2);
        s_rsp_vld = 1;
        #1;
        chk("t4_pop_blocked", 32'(m0_req_rdy), 32'd0);
        chk("t4_rsp_m0", 32'(m0_rsp_vld), 32'd1);
        cycle(0);
        s_rsp_vld = 0;
        #1;
        chk("t4_after_pop", 32'(m0_req_rdy), 32'd1);
        cycle(0);

        // T5: head owner back-pressure blocks the other requester's response
        do_reset();
        m0_req_vld = 1; s_req_rdy = 1;
        cycle(0);
        m0_req_vld = 0; m1_req_vld = 1;
        cycle(0);
        m1_req_vld = 0; s_rsp_vld = 1; m0_rsp_rdy = 0; m1_rsp_rdy = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t5_s_rsp_rdy", 32'(s_rsp_rdy),  32'd0);
            chk("t5_m1_rspv",   32'(m1_rsp_vld), 32'd0);
            cycle(0);
        end
        m0_rsp_rdy = 1;
        cycle(0);
        #1;
        chk("t5_m1_turn", 32'(m1_rsp_vld), 32'd1);
        cycle(0);

        // randomized traffic
        do_reset();
        repeat (3000) cycle(1);

        // T6: unexpected response, then reset while the grant is pinned
        do_reset();
        s_rsp_vld = 1;
        #1;
        chk("t6_drop_rdy", 32'(s_rsp_rdy), 32'd1);
        cycle(0);
        s_rsp_vld = 0;
        #1;
        chk("t6_err_set", 32'(err_unexp_rsp), 32'd1);
        m0_req_vld = 1; s_req_rdy = 1;
        cycle(0);
        m0_req_vld = 0; m1_req_vld = 1; m1_req_addr = 32'h400; s_req_rdy = 0;
        cycle(0);
        m0_req_vld = 1; m0_req_addr = 32'h500;
        #1;
        chk("t6_locked_addr", s_req_addr, 32'h400);
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("t6_rst_ot",    32'(ot_cnt),        32'd0);
        chk("t6_rst_err",   32'(err_unexp_rsp), 32'd0);
        chk("t6_rst_svld",  32'(s_req_vld),     32'd0);
        chk("t6_rst_srdy",  32'(s_rsp_rdy),     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        m0_req_vld = 1; m1_req_vld = 1; s_req_rdy = 1;
        #1;
        chk("t6_unlocked_m0", 32'(m0_req_rdy), 32'd1);
        cycle(0);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
